dfr_readout_engine: RTL and testbench

DFR_READOUT_ENGINE -- requirements
Module: dfr_readout_engine

---
 rtl/dfr_readout_engine.sv | 206 ++++++++++++++++++++
 tb/tb_dfr_readout_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_readout_engine.sv
// Delay-feedback reservoir readout engine: streams X (history) and W (output
// weights) from external memories, forms Z = X * W one dot product at a time
// and writes each saturated fixed-point result to the Z memory.
//
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | one (x_addr, w_addr) pair per cycle, x_cols cycles
//   DRAIN | MEM_LATENCY cycles while the last products return
//   WRITE | one cycle, z_wen=1 with the finished result
//   DONE  | one cycle, done=1
module dfr_readout_engine #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 4,
  parameter int MEM_LATENCY = 1,
  parameter int FRAC_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] x_rows,
  input  logic [ADDR_WIDTH-1:0] x_cols,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_data,
  output logic                  z_wen,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);

  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int PW   = 2 * DW;
  localparam int ACCW = PW + 8;
  localparam int JW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int LW   = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           cols_q, cols_d;
  logic [AW-1:0]           k_q, k_d;        // remaining issue cycles - 1
  logic [LW-1:0]           dr_q, dr_d;      // remaining drain cycles - 1
  logic [JW-1:0]           j_q, j_d;
  logic [AW-1:0]           r_q, r_d;        // remaining rows - 1
  logic [AW-1:0]           base_q, base_d;  // r * x_cols
  logic [AW-1:0]           zcnt_q, zcnt_d;  // next z write address
  logic [MEM_LATENCY-1:0]  vld_q, vld_d;    // read-return valid pipeline
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [AW-1:0]           x_addr_q, x_addr_d, w_addr_q, w_addr_d, z_addr_q, z_addr_d;
  logic [DW-1:0]           z_data_q, z_data_d;
  logic                    sat_q, sat_d;

  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_sum, acc_shift;
  logic                    res_sat;
  logic [DW-1:0]           res_val;

  // Full-precision product, accumulated only when a read return is valid.
  assign prod      = PW'($signed(x_data)) * PW'($signed(w_data));
  assign acc_sum   = acc_q + (vld_q[MEM_LATENCY-1] ? ACCW'(prod) : '0);
  assign acc_shift = acc_sum >>> FRAC_BITS;
  assign res_sat   = !((acc_shift[ACCW-1:DW-1] == '0) || (acc_shift[ACCW-1:DW-1] == '1));
  assign res_val   = res_sat ? (acc_shift[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                             : acc_shift[DW-1:0];

  // Next-state, counter and datapath update logic.
  always_comb begin
    state_d  = state_q;
    cols_d   = cols_q;
    k_d      = k_q;
    dr_d     = dr_q;
    j_d      = j_q;
    r_d      = r_q;
    base_d   = base_q;
    zcnt_d   = zcnt_q;
    x_addr_d = x_addr_q;
    w_addr_d = w_addr_q;
    z_addr_d = z_addr_q;
    z_data_d = z_data_q;
    sat_d    = sat_q;
    acc_d    = acc_sum;
    vld_d    = '0;
    vld_d[0] = (state_q == S_ISSUE);
    for (int i = 1; i < MEM_LATENCY; i++) vld_d[i] = vld_q[i-1];

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      vld_d   = '0;
      acc_d   = acc_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cols_d   = x_cols;
            k_d      = x_cols - 1'b1;
            r_d      = x_rows - 1'b1;
            j_d      = '0;
            base_d   = '0;
            zcnt_d   = '0;
            x_addr_d = '0;
            w_addr_d = '0;
            acc_d    = '0;
            sat_d    = 1'b0;
            state_d  = (x_rows == '0 || x_cols == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (k_q == '0) begin
            dr_d    = LW'(MEM_LATENCY - 1);
            state_d = S_DRAIN;
          end else begin
            k_d      = k_q - 1'b1;
            x_addr_d = x_addr_q + 1'b1;
            w_addr_d = w_addr_q + AW'(NUM_OUTPUTS);
          end
        end
        S_DRAIN: begin
          if (dr_q == '0) begin
            z_data_d = res_val;
            z_addr_d = zcnt_q;
            zcnt_d   = zcnt_q + 1'b1;
            sat_d    = sat_q | res_sat;
            state_d  = S_WRITE;
          end else begin
            dr_d = dr_q - 1'b1;
          end
        end
        S_WRITE: begin
          acc_d = '0;
          if (j_q == JW'(NUM_OUTPUTS - 1) && r_q == '0) begin
            state_d = S_DONE;
          end else begin
            k_d     = cols_q - 1'b1;
            state_d = S_ISSUE;
            if (j_q == JW'(NUM_OUTPUTS - 1)) begin
              j_d      = '0;
              r_d      = r_q - 1'b1;
              base_d   = base_q + cols_q;
              x_addr_d = base_q + cols_q;
              w_addr_d = '0;
            end else begin
              j_d      = j_q + 1'b1;
              x_addr_d = base_q;
              w_addr_d = AW'(j_q) + 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cols_q   <= '0;
      k_q      <= '0;
      dr_q     <= '0;
      j_q      <= '0;
      r_q      <= '0;
      base_q   <= '0;
      zcnt_q   <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      z_addr_q <= '0;
      z_data_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      k_q      <= k_d;
      dr_q     <= dr_d;
      j_q      <= j_d;
      r_q      <= r_d;
      base_q   <= base_d;
      zcnt_q   <= zcnt_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
      z_addr_q <= z_addr_d;
      z_data_q <= z_data_d;
      sat_q    <= sat_d;
    end
  end

  assign x_addr   = x_addr_q;
  assign w_addr   = w_addr_q;
  assign z_addr   = z_addr_q;
  assign z_data   = z_data_q;
  assign sat_flag = sat_q;
  assign z_wen    = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_WRITE);

endmodule

// File: tb/tb_dfr_readout_engine.sv
// Bench for dfr_readout_engine: unit 0 uses default parameters, unit 1 uses
// MEM_LATENCY=3, NUM_OUTPUTS=1. A matrix-level model predicts every cycle.
module tb_dfr_readout_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        st[2], ab[2];
  logic [16:0] xr[2], xc[2];
  logic signed [31:0] Xm[2][1024];
  logic signed [31:0] Wm[2][1024];

  logic [16:0] xa0, wa0, za0, xa1, wa1, za1;
  logic [31:0] xd0, wd0, zd0, xd1, wd1, zd1;
  logic [31:0] xp1[3], wp1[3];
  logic        zw0, bs0, dn0, sf0, zw1, bs1, dn1, sf1;

  dfr_readout_engine u0 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .x_rows(xr[0]), .x_cols(xc[0]),
    .x_addr(xa0), .x_data(xd0), .w_addr(wa0), .w_data(wd0), .z_addr(za0), .z_data(zd0),
    .z_wen(zw0), .busy(bs0), .done(dn0), .sat_flag(sf0));

  dfr_readout_engine #(.MEM_LATENCY(3), .NUM_OUTPUTS(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .x_rows(xr[1]), .x_cols(xc[1]),
    .x_addr(xa1), .x_data(xd1), .w_addr(wa1), .w_data(wd1), .z_addr(za1), .z_data(zd1),
    .z_wen(zw1), .busy(bs1), .done(dn1), .sat_flag(sf1));

  // Memories with the configured read latency.
  always @(posedge clk) begin
    xd0 <= Xm[0][xa0[9:0]];
    wd0 <= Wm[0][wa0[9:0]];
    xp1[0] <= Xm[1][xa1[9:0]]; xp1[1] <= xp1[0]; xp1[2] <= xp1[1];
    wp1[0] <= Wm[1][wa1[9:0]]; wp1[1] <= wp1[0]; wp1[2] <= wp1[1];
  end
  assign xd1 = xp1[2];
  assign wd1 = wp1[2];

  // Model state
  int          Ncfg[2] = '{4, 1};
  int          Lcfg[2] = '{1, 3};
  bit          run[2];
  int          off[2], T[2], per[2];
  bit          sat_exp[2];
  logic [31:0] ez_data[2][512];
  bit          ez_sat[2][512];
  logic [31:0] cap[2][$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected Z from plain matrix arithmetic on the memory contents.
  task automatic build(input int u, input int rows, input int cols);
    logic signed [127:0] a, p, sh;
    int n;
    n = Ncfg[u];
    per[u] = cols + Lcfg[u] + 1;
    T[u] = (rows == 0 || cols == 0) ? 0 : rows * n * per[u];
    for (int r = 0; r < rows; r++)
      for (int j = 0; j < n; j++) begin
        a = 0;
        for (int k = 0; k < cols; k++) begin
          p = Xm[u][(r*cols+k) % 1024];
          p = p * 128'(Wm[u][(k*n+j) % 1024]);
          a = a + p;
        end
        sh = a >>> 16;
        ez_sat[u][r*n+j] = (sh > 128'sd2147483647) || (sh < -128'sd2147483648);
        ez_data[u][r*n+j] = (sh > 128'sd2147483647) ? 32'h7FFFFFFF :
                            (sh < -128'sd2147483648) ? 32'h80000000 : sh[31:0];
      end
  endtask

  task automatic step_unit(input int u, input logic busy, input logic done, input logic wen,
                           input logic [16:0] za, input logic [31:0] zd, input logic sat);
    bit was_idle, eb, ed, ew;
    int i;
    if (rst) begin run[u] = 0; sat_exp[u] = 0; end
    was_idle = !run[u];
    eb = 0; ed = 0; ew = 0; i = 0;
    if (run[u]) begin
      off[u]++;
      if (off[u] == 1) sat_exp[u] = 0;
      if (off[u] <= T[u]) begin
        eb = 1;
        if (off[u] % per[u] == 0) begin
          ew = 1;
          i = off[u] / per[u] - 1;
          sat_exp[u] |= ez_sat[u][i];
        end
      end else ed = 1;
    end
    cmp($sformatf("busy%0d", u), 64'(busy), 64'(eb));
    cmp($sformatf("done%0d", u), 64'(done), 64'(ed));
    cmp($sformatf("z_wen%0d", u), 64'(wen), 64'(ew));
    cmp($sformatf("sat_flag%0d", u), 64'(sat), 64'(sat_exp[u]));
    if (ew) begin
      cmp($sformatf("z_addr%0d", u), 64'(za), 64'(i));
      cmp($sformatf("z_data%0d[%0d]", u, i), 64'(zd), 64'(ez_data[u][i]));
      cap[u].push_back(zd);
    end
    if (run[u] && (ab[u] || off[u] == T[u] + 1)) run[u] = 0;
    if (was_idle && st[u] && !rst) begin
      build(u, int'(xr[u]), int'(xc[u]));
      run[u] = 1;
      off[u] = 0;
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    step_unit(0, bs0, dn0, zw0, za0, zd0, sf0);
    step_unit(1, bs1, dn1, zw1, za1, zd1, sf1);
  end

  function automatic logic done_of(input int u);
    return (u == 0) ? dn0 : dn1;
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? bs0 : bs1;
  endfunction

  task automatic fill(input int u, input bit big);
    for (int i = 0; i < 1024; i++) begin
      Xm[u][i] = big ? $signed($urandom) : $signed(32'($urandom_range(0, 1048575)) - 32'sd524288);
      Wm[u][i] = big ? $signed($urandom) : $signed(32'($urandom_range(0, 1048575)) - 32'sd524288);
    end
  endtask

  // One run; returns the cycle offset (from the start cycle) at which done was seen.
  task automatic run_unit(input int u, input int rows, input int cols, input int abort_at,
                          input bit chg, output int done_off, output logic sat_c1);
    int c, n;
    cap[u].delete();
    done_off = -1;
    xr[u] = 17'(rows); xc[u] = 17'(cols);
    @(posedge clk); #1 st[u] = 1'b1;
    @(posedge clk); #1 st[u] = 1'b0;
    sat_c1 = (u == 0) ? sf0 : sf1;
    if (chg) begin xr[u] = 17'($urandom_range(0, 7)); xc[u] = 17'($urandom_range(0, 7)); end
    c = 1;
    for (n = 0; n < 5000; n++) begin
      ab[u] = (c == abort_at);
      if (abort_at > 0 && c == abort_at + 1) cmp("busy_after_abort", 64'(busy_of(u)), 64'd0);
      if (done_of(u)) done_off = c;
      if (done_of(u) || (abort_at > 0 && c > abort_at)) break;
      @(posedge clk); #1;
      c++;
    end
    ab[u] = 1'b0;
    if (n == 5000) begin
      miscompares++;
      $display("FAIL timeout unit%0d: no done after %0d cycles", u, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    logic s1;
    for (int u = 0; u < 2; u++) begin
      st[u] = 0; ab[u] = 0; xr[u] = 0; xc[u] = 0; run[u] = 0; sat_exp[u] = 0;
      for (int i = 0; i < 1024; i++) begin Xm[u][i] = 0; Wm[u][i] = 0; end
    end
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_busy", 64'(bs0), 0);  cmp("rst_done", 64'(dn0), 0);
    cmp("rst_zwen", 64'(zw0), 0);  cmp("rst_zdata", 64'(zd0), 0);
    rst = 1'b0;

    // Defaults: X all 1.0, W[k][j] = (j+1).0 -> z = 3.0*(j+1), done at 40+1.
    for (int i = 0; i < 1024; i++) begin
      Xm[0][i] = 32'h00010000;
      Wm[0][i] = 32'(((i % 4) + 1) << 16);
    end
    run_unit(0, 2, 3, 0, 0, d, s1);
    cmp("basic_done_off", 64'(d), 64'd41);
    cmp("basic_nwrites", 64'(cap[0].size()), 64'd8);
    for (int i = 0; i < 8 && i < cap[0].size(); i++)
      cmp($sformatf("basic_z[%0d]", i), 64'(cap[0][i]), 64'(32'h00030000 * ((i % 4) + 1)));

    // Zero rows / zero cols.
    run_unit(0, 0, 5, 0, 0, d, s1);
    cmp("zero_rows_done_off", 64'(d), 64'd1);
    cmp("zero_rows_nwrites", 64'(cap[0].size()), 64'd0);
    run_unit(0, 3, 0, 0, 0, d, s1);
    cmp("zero_cols_done_off", 64'(d), 64'd1);

    // Saturation, then the next start clears sat_flag.
    for (int i = 0; i < 1024; i++) begin Xm[0][i] = 32'h7FFF0000; Wm[0][i] = 32'h7FFF0000; end
    run_unit(0, 1, 2, 0, 0, d, s1);
    cmp("sat_z0", 64'(cap[0].size() > 0 ? cap[0][0] : 32'h0), 64'h7FFFFFFF);
    cmp("sat_flag_set", 64'(sf0), 64'd1);
    fill(0, 0);
    run_unit(0, 1, 2, 0, 0, d, s1);
    cmp("sat_flag_cleared", 64'(s1), 64'd0);

    // Long latency single-output run.
    fill(1, 0);
    run_unit(1, 4, 100, 0, 0, d, s1);
    cmp("lat3_done_off", 64'(d), 64'd417);

    // Abort in the 10th cycle, then a clean run.
    fill(0, 0);
    run_unit(0, 2, 3, 10, 0, d, s1);
    cmp("abort_no_done", 64'(d), 64'hFFFFFFFFFFFFFFFF);
    run_unit(0, 2, 3, 0, 0, d, s1);
    cmp("post_abort_done_off", 64'(d), 64'd41);

    // Reset between edges mid-run.
    xr[0] = 3; xc[0] = 5;
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("arst_busy", 64'(bs0), 0);   cmp("arst_done", 64'(dn0), 0);
    cmp("arst_zwen", 64'(zw0), 0);   cmp("arst_sat", 64'(sf0), 0);
    cmp("arst_xaddr", 64'(xa0), 0);  cmp("arst_waddr", 64'(wa0), 0);
    cmp("arst_zaddr", 64'(za0), 0);  cmp("arst_zdata", 64'(zd0), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_unit(0, 2, 2, 0, 0, d, s1);
    cmp("post_rst_done_off", 64'(d), 64'(2 * 4 * 4 + 1));

    // Randomized runs; dimensions change mid-run and must be ignored.
    for (int t = 0; t < 12; t++) begin
      int rr, cc;
      rr = $urandom_range(1, 3);
      cc = $urandom_range(1, 6);
      fill(0, (t % 3) == 0);
      run_unit(0, rr, cc, 0, 1, d, s1);
      cmp("rand_done_off", 64'(d), 64'(rr * 4 * (cc + 2) + 1));
    end
    for (int t = 0; t < 2; t++) begin
      int rr, cc;
      rr = $urandom_range(1, 3);
      cc = $urandom_range(1, 20);
      fill(1, t == 1);
      run_unit(1, rr, cc, 0, 1, d, s1);
      cmp("rand1_done_off", 64'(d), 64'(rr * (cc + 4) + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
